// File: rtl/sync_down_counter_pkg.sv
// Shared constants and helpers for the sync_down_counter block.
package sync_down_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam logic [31:0] RESET_VALUE   = 32'h0000_0000;

  // Value the counter reaches one edge after leaving zero, for a given width.
  function automatic logic [31:0] all_ones(input int unsigned width);
    if (width >= 32)
      return 32'hFFFF_FFFF;
    else
      return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_down_counter_t_flip_flop.sv
// T flip-flop used as one bit slice of the structural down counter.
module t_flip_flop (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/sync_down_counter.sv
// Free-running WIDTH-bit synchronous down counter with async active-low reset.
// Define SYNC_DOWN_COUNTER_STRUCTURAL_EN to build it from a T flip-flop borrow chain.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_down_counter: WIDTH must be in 1..32");
  end

`ifdef SYNC_DOWN_COUNTER_STRUCTURAL_EN

  // A bit toggles only when every lower bit is zero, i.e. a borrow reaches it.
  logic [WIDTH-1:0] borrow;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign borrow[i] = 1'b1;
    end else begin : g_upper
      assign borrow[i] = borrow[i-1] & ~out[i-1];
    end

    t_flip_flop u_tff (
      .clk (clk),
      .rst (rst),
      .t   (borrow[i]),
      .q   (out[i])
    );
  end

`else

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      out <= RST_VAL;
    else
      out <= out - ONE;
  end

`endif

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter (WIDTH=4 and WIDTH=1 instances).
module tb_sync_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] out4;
  logic [0:0] out1;

  int checks = 0;
  int errors = 0;

  // Hand-written descending sequence seen on edges 1..16 after reset release.
  logic [3:0] seq4 [16] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
                            4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
  logic [0:0] seq1 [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .out (out4)
  );

  sync_down_counter #(.WIDTH(1)) dut_w1 (
    .clk (clk),
    .rst (rst),
    .out (out1)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out4 !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_async out=%h expected=%h", out4, 4'h0);
    end
    checks++;
    if (out1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async_w1 out=%h expected=%h", out1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out4 !== 4'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold edge=%0d out=%h expected=%h", i, out4, 4'h0);
      end
    end
  endtask

  task automatic test_first_period();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out4 !== seq4[i]) begin
        errors++;
        $display("[TB] FAIL first_period edge=%0d out=%h expected=%h", i + 1, out4, seq4[i]);
      end
    end
  endtask

  task automatic test_two_periods();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out4 !== seq4[(i - 1) % 16]) begin
        errors++;
        $display("[TB] FAIL two_periods edge=%0d out=%h expected=%h", i, out4, seq4[(i - 1) % 16]);
      end
    end
  endtask

  task automatic test_mid_count_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out4 !== 4'hA) begin
      errors++;
      $display("[TB] FAIL mid_reach_a out=%h expected=%h", out4, 4'hA);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out4 !== 4'h0) begin
      errors++;
      $display("[TB] FAIL mid_async_clear out=%h expected=%h", out4, 4'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out4 !== 4'h0) begin
      errors++;
      $display("[TB] FAIL mid_hold out=%h expected=%h", out4, 4'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out4 !== 4'hF) begin
      errors++;
      $display("[TB] FAIL mid_restart_first out=%h expected=%h", out4, 4'hF);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out4 !== 4'hE) begin
      errors++;
      $display("[TB] FAIL mid_restart_second out=%h expected=%h", out4, 4'hE);
    end
  endtask

  task automatic test_width1();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w1_reset out=%h expected=%h", out1, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out1 !== seq1[i]) begin
        errors++;
        $display("[TB] FAIL w1_sequence edge=%0d out=%h expected=%h", i + 1, out1, seq1[i]);
      end
    end
  endtask

  initial begin
    $display("[TB] sync_down_counter directed tests starting");
    test_reset();
    test_first_period();
    test_two_periods();
    test_mid_count_reset();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
